uart_tx_core: RTL and testbench

- UART transmitter: the transmit-side counterpart of the system's UART receive path.
- Accepts a parallel word with a valid strobe, latches it, and serialises it on TX_OUT.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, stop bit (1).
- Runs on the UART TX clock domain, one bit per Clk cycle; upstream (register file / async FIFO read side) presents words via Data_Valid.

---
 rtl/uart_tx_core.sv | 122 ++++++++++++
 tb/tb_uart_tx_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, stop; one bit per Clk.
// UART_TX_TWO_STOP_EN selects a two-cycle stop bit. Words are taken only in IDLE; Data_Valid while Busy is dropped.
module uart_tx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         bit_cnt_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_bit_q;
   logic                  tx_q;
   logic                  busy_q;
`ifdef UART_TX_TWO_STOP_EN
   logic                  stop_cnt_q;
`endif

   logic                  par_bit_d;
   logic [CW-1:0]         bit_cnt_d;

   // Odd parity is the inverted XOR, so PAR_TYP folds straight in.
   assign par_bit_d = (^P_DATA) ^ PAR_TYP;
   assign bit_cnt_d = bit_cnt_q + 1'b1;

   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_cnt_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (Data_Valid) begin
                  data_q    <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_bit_q <= par_bit_d;
                  state_q   <= START;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               state_q <= DATA;
               tx_q    <= data_q[0];
            end
            // Outputs are registered, so each branch loads the bit the next state shows.
            DATA: begin
               if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                  bit_cnt_q <= '0;
                  if (par_en_q) begin
                     state_q <= PARITY;
                     tx_q    <= par_bit_q;
                  end else begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_d;
                  tx_q      <= data_q[bit_cnt_d];
               end
            end
            PARITY: begin
               state_q <= STOP;
               tx_q    <= 1'b1;
            end
            STOP: begin
               tx_q <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
               if (!stop_cnt_q) begin
                  stop_cnt_q <= 1'b1;
               end else begin
                  stop_cnt_q <= 1'b0;
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
               end
`else
               state_q <= IDLE;
               busy_q  <= 1'b0;
`endif
            end
            default: begin
               state_q   <= IDLE;
               bit_cnt_q <= '0;
               tx_q      <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: expected frames queued at drive time, popped when Busy rises.
module tb_uart_tx_core;

   localparam int DW = 8;

   logic          Clk;
   logic          RST;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic          TX_OUT;
   logic          Busy;

   uart_tx_core #(.DATA_WIDTH(DW)) dut (
      .Clk        (Clk),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] bits;
      int          len;
   } frame_t;

   frame_t sb[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic frame_t mk(input logic [DW-1:0] d, input logic pe, input logic pt);
      frame_t f;
      int     n;
      f.bits    = '1;
      f.bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) f.bits[1+i] = d[i];
      n = 1 + DW;
      if (pe) begin
         f.bits[n] = (^d) ^ pt;
         n++;
      end
      f.bits[n] = 1'b1;
      n++;
`ifdef UART_TX_TWO_STOP_EN
      f.bits[n] = 1'b1;
      n++;
`endif
      f.len = n;
      return f;
   endfunction

   task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
      @(posedge Clk);
      #1;
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      sb.push_back(mk(d, pe, pt));
      @(posedge Clk);
      #1;
      Data_Valid = 1'b0;
   endtask

   // gap returns the number of idle cycles seen before Busy rose.
   task automatic wait_frame(output int gap);
      frame_t f;
      int     n;
      n = 0;
      @(negedge Clk);
      while (!Busy && n < 60) begin
         @(negedge Clk);
         n++;
      end
      gap = n;
      if (!Busy) begin
         check("start_timeout", 32'(Busy), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check("sb_underflow", 32'(sb.size()), 32'd1);
         return;
      end
      f = sb.pop_front();
      for (int i = 0; i < f.len; i++) begin
         check($sformatf("tx_bit%0d", i), 32'(TX_OUT), 32'(f.bits[i]));
         check($sformatf("busy_bit%0d", i), 32'(Busy), 32'd1);
         @(negedge Clk);
      end
      check("busy_after", 32'(Busy), 32'd0);
      check("tx_after", 32'(TX_OUT), 32'd1);
   endtask

   task automatic check_idle(input string tag, input int cycles);
      int bad;
      bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clk);
         if (Busy || !TX_OUT) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   int gap;

   initial begin
      RST        = 1'b0;
      P_DATA     = '0;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      #12;
      check("rst_tx", 32'(TX_OUT), 32'd1);
      check("rst_busy", 32'(Busy), 32'd0);
      @(posedge Clk);
      #2;
      RST = 1'b1;

      // Parity and length variants
      send(DW'(8'hA5), 1'b1, 1'b0);
      wait_frame(gap);
      send(DW'(8'h01), 1'b1, 1'b1);
      wait_frame(gap);
      send(DW'(8'hFF), 1'b0, 1'b0);
      wait_frame(gap);
      send(DW'(8'h55), 1'b1, 1'b0);
      wait_frame(gap);

      // Second word offered mid-frame must be dropped
      send(DW'(8'h3C), 1'b1, 1'b0);
      fork
         wait_frame(gap);
         begin
            repeat (3) @(posedge Clk);
            #1;
            P_DATA     = DW'(8'h55);
            Data_Valid = 1'b1;
            @(posedge Clk);
            #1;
            Data_Valid = 1'b0;
         end
      join
      check_idle("no_second_frame", 20);

      // Data_Valid held: inputs change mid-frame, second frame follows after one idle cycle
      @(posedge Clk);
      #1;
      P_DATA     = DW'(8'h0F);
      PAR_EN     = 1'b1;
      PAR_TYP    = 1'b0;
      Data_Valid = 1'b1;
      sb.push_back(mk(DW'(8'h0F), 1'b1, 1'b0));
      sb.push_back(mk(DW'(8'hF0), 1'b1, 1'b1));
      fork
         begin
            wait_frame(gap);
            wait_frame(gap);
            check("idle_gap", 32'(gap + 1), 32'd1);
         end
         begin
            repeat (3) @(posedge Clk);
            #1;
            P_DATA  = DW'(8'hF0);
            PAR_TYP = 1'b1;
            repeat (14) @(posedge Clk);
            #1;
            Data_Valid = 1'b0;
         end
      join
      check_idle("idle_after_held", 10);

      // Asynchronous reset during data bit 5 (a 0 bit), then a clean frame
      @(posedge Clk);
      #1;
      P_DATA     = DW'(8'h0F);
      PAR_EN     = 1'b1;
      PAR_TYP    = 1'b0;
      Data_Valid = 1'b1;
      @(posedge Clk);
      #1;
      Data_Valid = 1'b0;
      @(negedge Clk);
      repeat (6) @(negedge Clk);
      check("pre_rst_bit5", 32'(TX_OUT), 32'd0);
      #2;
      RST = 1'b0;
      #1;
      check("rst_mid_tx", 32'(TX_OUT), 32'd1);
      check("rst_mid_busy", 32'(Busy), 32'd0);
      @(posedge Clk);
      #2;
      RST = 1'b1;
      check_idle("idle_after_rst", 3);
      send(DW'(8'h81), 1'b1, 1'b0);
      wait_frame(gap);

      for (int k = 0; k < 6; k++) begin
         send(DW'($urandom), 1'($urandom), 1'($urandom));
         wait_frame(gap);
      end

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
